tree_walk_ctrl: RTL

TREE_WALK_CTRL -- requirements
Module: tree_walk_ctrl

---
 rtl/tree_pkg.sv | 36 +++
 rtl/tree_walk_ctrl_node_decode.sv | 30 +++
 rtl/tree_walk_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tree_pkg.sv
// Shared definitions for the decision-tree walk controller: FSM states,
// node-word field layout and the per-channel node count.
package tree_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        WAIT_DIR,
        EMIT
    } state_t;

    localparam int FLAGS_W = 2;

    // Nodes per channel in a complete tree of the given depth.
    function automatic int node_count(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int coeff_lsb(input int bias_w);
        return bias_w;
    endfunction

    function automatic int one_lsb(input int features, input int coeff_w, input int bias_w);
        return bias_w + (features - 1) * coeff_w;
    endfunction

    function automatic int flags_lsb(input int features, input int coeff_w, input int bias_w);
        return one_lsb(features, coeff_w, bias_w) + features;
    endfunction

    function automatic int word_width(input int features, input int coeff_w, input int bias_w);
        return flags_lsb(features, coeff_w, bias_w) + FLAGS_W;
    endfunction

endpackage

// File: rtl/tree_walk_ctrl_node_decode.sv
// Splits a registered node word {child_flags, one_pos, coeff[0..], bias}
// into its fields; coeff[0] sits at the most significant coefficient slot.
module node_decode
    import tree_pkg::*;
#(
    parameter int FEATURES = 3,
    parameter int COEFF_W  = 4,
    parameter int BIAS_W   = 10,
    localparam int WORD_W  = word_width(FEATURES, COEFF_W, BIAS_W)
) (
    input  logic [WORD_W-1:0]                word,
    output logic [1:0]                       child_flags,
    output logic [FEATURES-1:0]              one_pos,
    output logic [FEATURES-2:0][COEFF_W-1:0] coeffs,
    output logic [BIAS_W-1:0]                bias
);

    localparam int COEFF_LSB = coeff_lsb(BIAS_W);
    localparam int ONE_LSB   = one_lsb(FEATURES, COEFF_W, BIAS_W);
    localparam int FLAGS_LSB = flags_lsb(FEATURES, COEFF_W, BIAS_W);

    assign child_flags = word[FLAGS_LSB +: FLAGS_W];
    assign one_pos     = word[ONE_LSB +: FEATURES];
    assign bias        = word[BIAS_W-1:0];

    for (genvar i = 0; i < FEATURES - 1; i++) begin : g_coeff
        assign coeffs[i] = word[COEFF_LSB + (FEATURES - 2 - i) * COEFF_W +: COEFF_W];
    end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Walks a per-channel decision tree: fetches a node, streams its linear
// terms to an external datapath, then follows the returned sign bit.
module tree_walk_ctrl
    import tree_pkg::*;
#(
    parameter int FEATURES   = 3,
    parameter int COEFF_W    = 4,
    parameter int BIAS_W     = 10,
    parameter int TREE_DEPTH = 3,
    parameter int CHANNELS   = 16,
    parameter int MEM_LAT    = 1,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int NODES     = node_count(TREE_DEPTH),
    localparam int ADDR_W    = (CHANNELS * NODES > 1) ? $clog2(CHANNELS * NODES) : 1,
    localparam int WORD_W    = word_width(FEATURES, COEFF_W, BIAS_W),
    localparam int FS_W      = (FEATURES > 1) ? $clog2(FEATURES) : 1,
    localparam int LVL_W     = $clog2(TREE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [WORD_W-1:0]     mem_rdata,
    output logic                  load_bias,
    output logic                  add,
    output logic                  mult,
    output logic [FS_W-1:0]       feat_sel,
    output logic [COEFF_W-1:0]    coeff,
    output logic [BIAS_W-1:0]     bias,
    input  logic                  dir_valid,
    input  logic                  dir,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [TREE_DEPTH-1:0] out_path,
    output logic [LVL_W-1:0]      out_level
);

    localparam int NODE_W  = TREE_DEPTH;
    localparam int CNT_MAX = (MEM_LAT > FEATURES) ? MEM_LAT : FEATURES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [FS_W-1:0]         coeff_idx;
    logic [NODE_W-1:0]       node;
    logic [TREE_DEPTH-1:0]   path;
    logic [LVL_W-1:0]        level;
    logic [LVL_W-1:0]        level_inc;
    logic [CH_W-1:0]         ch_q;
    logic [WORD_W-1:0]       word_q;

    logic [1:0]                       child_flags;
    logic [FEATURES-1:0]              one_pos;
    logic [FEATURES-2:0][COEFF_W-1:0] coeffs;
    logic [BIAS_W-1:0]                node_bias;

    logic                    is_unit;
    logic [COEFF_W-1:0]      cur_coeff;
    logic                    take_child;

    node_decode #(
        .FEATURES (FEATURES),
        .COEFF_W  (COEFF_W),
        .BIAS_W   (BIAS_W)
    ) u_node_decode (
        .word        (word_q),
        .child_flags (child_flags),
        .one_pos     (one_pos),
        .coeffs      (coeffs),
        .bias        (node_bias)
    );

    assign mem_addr   = ADDR_W'(ch_q) * ADDR_W'(NODES) + ADDR_W'(node);
    assign out_ch     = ch_q;
    assign out_path   = path;
    assign out_level  = level;
    assign level_inc  = level + 1'b1;
    assign take_child = (dir ? child_flags[0] : child_flags[1])
                        && (level_inc < LVL_W'(TREE_DEPTH));

    // one_pos is listed MSB-first, so feature f maps to bit FEATURES-1-f.
    always_comb begin
        is_unit   = 1'b0;
        cur_coeff = '0;
        for (int f = 0; f < FEATURES; f++) begin
            if (cnt == CNT_W'(f)) is_unit = one_pos[FEATURES-1-f];
        end
        for (int i = 0; i < FEATURES - 1; i++) begin
            if (coeff_idx == FS_W'(i)) cur_coeff = coeffs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_rd     = 1'b0;
        load_bias  = 1'b0;
        add        = 1'b0;
        mult       = 1'b0;
        feat_sel   = '0;
        coeff      = '0;
        bias       = '0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) state_next = FETCH;
            end
            FETCH: begin
                mem_rd = (cnt == '0);
                if (cnt == CNT_W'(MEM_LAT)) state_next = EVAL;
            end
            EVAL: begin
                feat_sel  = FS_W'(cnt);
                load_bias = (cnt == '0);
                if (cnt == '0) bias = node_bias;
                if (is_unit) begin
                    add = 1'b1;
                end else if (cur_coeff != '0) begin
                    add   = 1'b1;
                    mult  = 1'b1;
                    coeff = cur_coeff;
                end
                if (cnt == CNT_W'(FEATURES - 1)) state_next = WAIT_DIR;
            end
            WAIT_DIR: begin
                if (dir_valid) state_next = take_child ? FETCH : EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Traversal context; cnt is reused as the fetch-latency and feature counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            coeff_idx <= '0;
            node      <= '0;
            path      <= '0;
            level     <= '0;
            ch_q      <= '0;
            word_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        ch_q  <= in_ch;
                        node  <= '0;
                        path  <= '0;
                        level <= '0;
                        cnt   <= '0;
                    end
                end
                FETCH: begin
                    if (cnt == CNT_W'(MEM_LAT)) begin
                        word_q    <= mem_rdata;
                        cnt       <= '0;
                        coeff_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (!is_unit) coeff_idx <= coeff_idx + 1'b1;
                    if (cnt == CNT_W'(FEATURES - 1)) cnt <= '0;
                    else                             cnt <= cnt + 1'b1;
                end
                WAIT_DIR: begin
                    if (dir_valid) begin
                        for (int i = 0; i < TREE_DEPTH; i++) begin
                            if (level == LVL_W'(i)) path[i] <= dir;
                        end
                        level <= level_inc;
                        if (take_child) begin
                            node <= (node << 1) + NODE_W'(1) + NODE_W'(dir);
                            cnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
